// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the serializer state encoding.
`timescale 1ns/1ps
package uart_pkg;

  // Word offsets within the 16-byte window, taken from a[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVERRUN = 3;
  localparam int ST_COUNT   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-bus port of the UART: store strobe, address, store data, read data, hit.
// Both directions are single-cycle: a store lands on the rising edge while we=1,
// and rd/hit are purely combinational from a; there is no valid/ready backpressure.
`timescale 1ns/1ps
interface mmio_uart_tx_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;

  modport master (output we, output a, output wd, input rd, input hit);
  modport slave  (input we, input a, input wd, output rd, output hit);
endinterface

// File: rtl/mmio_uart_tx_fifo.sv
// Circular-buffer FIFO feeding the serializer; a push into a full FIFO is only
// accepted when a pop frees a slot on the same edge.
`timescale 1ns/1ps
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH[AW:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointer wrap is plain overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: register decode, TX FIFO and 8N1 serializer.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
`timescale 1ns/1ps
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DIV_WIDTH  = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(16)
) (
  input  logic                clk,
  input  logic                reset,
  mmio_uart_tx_if.slave       bus,
  output logic                tx,
  output tx_state_t           dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                 hit;
  logic [1:0]           off;
  logic                 wr;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [7:0]           fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic                 overrun;
  logic [DIV_WIDTH-1:0] div;
  logic [31:0]          status;
  logic [31:0]          rd_w;
  logic                 unused_bits;

  tx_state_t            state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [7:0]           sh, sh_n;
  logic                 tx_q, tx_n;
  logic                 bit_done;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_n;
`endif

  assign hit         = (bus.a[31:4] == BASE_ADDR[31:4]);
  assign off         = bus.a[3:2];
  assign wr          = bus.we && hit;
  assign fifo_push   = wr && (off == REG_TXDATA);
  assign bus.hit     = hit;
  assign unused_bits = ^{bus.a[1:0], bus.wd[31:DIV_WIDTH]};

  tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (bus.wd[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A push into a full FIFO is only lost when the serializer is not popping that edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
      div     <= DIV_RESET;
    end else begin
      if (fifo_push && fifo_full && !fifo_pop)
        overrun <= 1'b1;
      else if (wr && (off == REG_STATUS) && bus.wd[ST_OVERRUN])
        overrun <= 1'b0;
      if (wr && (off == REG_DIV))
        div <= bus.wd[DIV_WIDTH-1:0];
    end
  end

  always_comb begin
    status                 = '0;
    status[ST_COUNT +: CW] = fifo_count;
    status[ST_OVERRUN]     = overrun;
    status[ST_BUSY]        = (state != IDLE);
    status[ST_FULL]        = fifo_full;
    status[ST_EMPTY]       = fifo_empty;
  end

  always_comb begin
    rd_w = '0;
    if (hit) begin
      case (off)
        REG_STATUS: rd_w = status;
        REG_DIV:    rd_w[DIV_WIDTH-1:0] = div;
        default:    rd_w = '0;
      endcase
    end
  end
  assign bus.rd = rd_w;

  // cnt is reloaded from div only at bit boundaries, so a DIV store mid-bit
  // never stretches or shortens the bit in flight
  assign bit_done = (cnt == '0);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    sh_n     = sh;
    tx_n     = tx_q;
    fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n    = par_q;
`endif
    case (state)
      IDLE: begin
        tx_n     = 1'b1;
        fifo_pop = !fifo_empty;
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          idx_n   = '0;
          cnt_n   = div;
          tx_n    = sh[0];
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_n = div;
          if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n = idx + 3'd1;
            sh_n  = {1'b0, sh[7:1]};
            tx_n  = sh[1];
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_n = STOP;
          cnt_n   = div;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          state_n  = IDLE;
          tx_n     = 1'b1;
          fifo_pop = !fifo_empty;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase

    // Loading a byte always opens a start bit, from IDLE or straight out of STOP
    if (fifo_pop) begin
      state_n = START;
      sh_n    = fifo_dout;
      cnt_n   = div;
      tx_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n   = ^fifo_dout;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      tx_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      tx_q  <= tx_n;
`ifdef UART_TX_PARITY_EN
      par_q <= par_n;
`endif
    end
  end

  assign tx        = tx_q;
  assign dbg_state = state;
endmodule
